// File: rtl/ntt_pkg.sv
// Shared types and helpers for the NTT address/control stage.
// Holds the FSM state encoding, the CLOG2 helper macro and a bit-reverse
// function used when BITREV_OUT_EN puts the final stage in natural order.

`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif

package ntt_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    localparam int BR_W = 32;

    // Reverses the low w bits of v; bits at and above w come back 0.
    function automatic logic [BR_W-1:0] bitrev(
        input logic [BR_W-1:0] v,
        input int              w
    );
        logic [BR_W-1:0] r;
        r = '0;
        for (int i = 0; i < BR_W; i++) begin
            if (i < w) r[i] = v[w-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/ntt_wr_delay.sv
// Fixed-depth valid+data pipeline that realigns read-side information
// with butterfly results.
// Ports: clk, rst_n (async active-low), vld_i/dat_i in, vld_o/dat_o out
// exactly DLY cycles later. DLY must be >= 1.

module ntt_wr_delay
    import ntt_pkg::*;
#(
    parameter int DLY = 1,
    parameter int DW  = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          vld_i,
    input  logic [DW-1:0] dat_i,
    output logic          vld_o,
    output logic [DW-1:0] dat_o
);

    logic [DLY-1:0] vld_q;
    logic [DW-1:0]  dat_q [DLY];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < DLY; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= vld_i;
            dat_q[0] <= dat_i;
            for (int i = 1; i < DLY; i++) begin
                vld_q[i] <= vld_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
        end
    end

    assign vld_o = vld_q[DLY-1];
    assign dat_o = dat_q[DLY-1];

endmodule

// File: rtl/ntt_addr_gen.sv
// Stage sequencer and address generator for an in-place radix-2
// Gentleman-Sande NTT over two ping-pong banks, one butterfly per cycle.
// Ports: clk, rst_n (async active-low), start in; busy, done, rd_en,
// rd_addr_a/b, tw_idx, wr_en, wr_addr_a/b, src_bank, stage out.
// Build option: BITREV_OUT_EN bit-reverses last-stage write addresses
// so the result lands in natural order.

module ntt_addr_gen
    import ntt_pkg::*;
#(
    parameter int N      = 64,
    parameter int BF_LAT = 4,
    parameter int AW     = `CLOG2(N),
    parameter int SW     = `CLOG2(`CLOG2(N))
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr_a,
    output logic [AW-1:0] rd_addr_b,
    output logic [AW-2:0] tw_idx,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr_a,
    output logic [AW-1:0] wr_addr_b,
    output logic          src_bank,
    output logic [SW-1:0] stage
);

    localparam int L      = AW;
    localparam int WR_DLY = 1 + BF_LAT;
    localparam int HALF_N = N / 2;
    localparam int CW     = $clog2(WR_DLY + 1);

    typedef struct packed {
        logic [AW-1:0] a;
        logic [AW-1:0] b;
        logic [AW-2:0] tw;
    } rd_t;

    // half = 2^(L-1-s), so group*2*half is k with its low
    // offset bits cleared, shifted up by one.
    function automatic rd_t bfly(
        input logic [SW-1:0] s,
        input logic [AW-2:0] k
    );
        rd_t           r;
        logic [AW-1:0] half;
        logic [AW-1:0] msk;
        logic [AW-1:0] kk;
        half = AW'(HALF_N) >> s;
        msk  = half - 1'b1;
        kk   = {1'b0, k};
        r.a  = ((kk & ~msk) << 1) | (kk & msk);
        r.b  = r.a + half;
        r.tw = (AW-1)'((kk & msk) << s);
        return r;
    endfunction

    state_e        state_q;
    logic [SW-1:0] stage_q;
    logic [AW-2:0] k_q;
    logic [CW-1:0] cnt_q;
    logic          src_q;
    logic          busy_q;
    logic          done_q;
    logic          rd_en_q;
    rd_t           rd_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            stage_q <= '0;
            k_q     <= '0;
            cnt_q   <= '0;
            src_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_en_q <= 1'b0;
            rd_q    <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_READ;
                        stage_q <= '0;
                        k_q     <= '0;
                        src_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        rd_en_q <= 1'b1;
                        rd_q    <= bfly('0, '0);
                    end
                end
                S_READ: begin
                    if (k_q == (AW-1)'(HALF_N - 1)) begin
                        state_q <= S_DRAIN;
                        cnt_q   <= CW'(WR_DLY - 1);
                        rd_en_q <= 1'b0;
                    end else begin
                        k_q  <= k_q + 1'b1;
                        rd_q <= bfly(stage_q, k_q + 1'b1);
                    end
                end
                S_DRAIN: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else if (stage_q == SW'(L - 1)) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= S_READ;
                        stage_q <= stage_q + 1'b1;
                        src_q   <= ~src_q;
                        k_q     <= '0;
                        rd_en_q <= 1'b1;
                        rd_q    <= bfly(stage_q + 1'b1, '0);
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign rd_en     = rd_en_q;
    assign rd_addr_a = rd_q.a;
    assign rd_addr_b = rd_q.b;
    assign tw_idx    = rd_q.tw;
    assign src_bank  = src_q;
    assign stage     = stage_q;

    logic [2*AW-1:0] dly_dat;
    logic [AW-1:0]   dly_a;
    logic [AW-1:0]   dly_b;

    ntt_wr_delay #(
        .DLY (WR_DLY),
        .DW  (2 * AW)
    ) u_wr_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .vld_i (rd_en_q),
        .dat_i ({rd_q.a, rd_q.b}),
        .vld_o (wr_en),
        .dat_o (dly_dat)
    );

    assign dly_a = dly_dat[2*AW-1:AW];
    assign dly_b = dly_dat[AW-1:0];

`ifdef BITREV_OUT_EN
    // Stage only advances after the pipe drains, so stage_q still
    // names the stage whose results are being written.
    logic last_stage;
    assign last_stage = (stage_q == SW'(L - 1));
    assign wr_addr_a  = last_stage ?
                        AW'(bitrev(BR_W'(dly_a), AW)) : dly_a;
    assign wr_addr_b  = last_stage ?
                        AW'(bitrev(BR_W'(dly_b), AW)) : dly_b;
`else
    assign wr_addr_a = dly_a;
    assign wr_addr_b = dly_b;
`endif

endmodule

// File: tb/tb_ntt_addr_gen.sv
// Self-checking bench for ntt_addr_gen: two instances (N=8/BF_LAT=2 and
// N=64/BF_LAT=0) checked cycle by cycle against a transform-level model.

module tb_ntt_addr_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_a = 1'b0;
    logic start_b = 1'b0;

    always #5 clk = ~clk;

    logic       a_busy, a_done, a_rd_en, a_wr_en, a_src;
    logic [2:0] a_rda, a_rdb, a_wra, a_wrb;
    logic [1:0] a_tw, a_stage;

    logic       b_busy, b_done, b_rd_en, b_wr_en, b_src;
    logic [5:0] b_rda, b_rdb, b_wra, b_wrb;
    logic [4:0] b_tw;
    logic [2:0] b_stage;

    ntt_addr_gen #(.N(8), .BF_LAT(2)) u_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start_a),
        .busy      (a_busy),
        .done      (a_done),
        .rd_en     (a_rd_en),
        .rd_addr_a (a_rda),
        .rd_addr_b (a_rdb),
        .tw_idx    (a_tw),
        .wr_en     (a_wr_en),
        .wr_addr_a (a_wra),
        .wr_addr_b (a_wrb),
        .src_bank  (a_src),
        .stage     (a_stage)
    );

    ntt_addr_gen #(.N(64), .BF_LAT(0)) u_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start_b),
        .busy      (b_busy),
        .done      (b_done),
        .rd_en     (b_rd_en),
        .rd_addr_a (b_rda),
        .rd_addr_b (b_rdb),
        .tw_idx    (b_tw),
        .wr_en     (b_wr_en),
        .wr_addr_a (b_wra),
        .wr_addr_b (b_wrb),
        .src_bank  (b_src),
        .stage     (b_stage)
    );

    int tests = 0;
    int fails = 0;
    int sel = 0;

    logic [31:0] o_busy, o_done, o_rd_en, o_wr_en, o_src, o_stage;
    logic [31:0] o_rda, o_rdb, o_tw, o_wra, o_wrb;

    assign o_busy  = sel != 0 ? 32'(b_busy)  : 32'(a_busy);
    assign o_done  = sel != 0 ? 32'(b_done)  : 32'(a_done);
    assign o_rd_en = sel != 0 ? 32'(b_rd_en) : 32'(a_rd_en);
    assign o_wr_en = sel != 0 ? 32'(b_wr_en) : 32'(a_wr_en);
    assign o_src   = sel != 0 ? 32'(b_src)   : 32'(a_src);
    assign o_stage = sel != 0 ? 32'(b_stage) : 32'(a_stage);
    assign o_rda   = sel != 0 ? 32'(b_rda)   : 32'(a_rda);
    assign o_rdb   = sel != 0 ? 32'(b_rdb)   : 32'(a_rdb);
    assign o_tw    = sel != 0 ? 32'(b_tw)    : 32'(a_tw);
    assign o_wra   = sel != 0 ? 32'(b_wra)   : 32'(a_wra);
    assign o_wrb   = sel != 0 ? 32'(b_wrb)   : 32'(a_wrb);

    function automatic int pts();
        return sel != 0 ? 64 : 8;
    endfunction

    function automatic int wdly();
        return sel != 0 ? 1 : 3;
    endfunction

    function automatic int bitrev_i(int v, int w);
        int r = 0;
        for (int i = 0; i < w; i++) begin
            if (((v >> i) & 1) != 0) r |= 1 << (w - 1 - i);
        end
        return r;
    endfunction

    // Butterfly k of stage s, straight from the addressing rules.
    task automatic bf(input int n, input int s, input int k,
                      output int a, output int b, output int tw);
        int l, shift, half, grp, off;
        l     = $clog2(n);
        shift = l - 1 - s;
        half  = n >> (s + 1);
        grp   = k >> shift;
        off   = k & (half - 1);
        a     = grp * 2 * half + off;
        b     = a + half;
        tw    = (off << s) & (n / 2 - 1);
    endtask

    task automatic chk(input string tag, input int t,
                       input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s dut=%0d t=%0d observed=%0d expected=%0d",
                   tag, sel, t, obs, exp);
        end
    endtask

    task automatic check_idle(input int t);
        chk("idle_busy", t, o_busy, 0);
        chk("idle_done", t, o_done, 0);
        chk("idle_rd_en", t, o_rd_en, 0);
        chk("idle_wr_en", t, o_wr_en, 0);
    endtask

    task automatic check_zero(input int t);
        check_idle(t);
        chk("rst_src", t, o_src, 0);
        chk("rst_stage", t, o_stage, 0);
        chk("rst_rda", t, o_rda, 0);
        chk("rst_rdb", t, o_rdb, 0);
        chk("rst_tw", t, o_tw, 0);
        chk("rst_wra", t, o_wra, 0);
        chk("rst_wrb", t, o_wrb, 0);
    endtask

    // t counts cycles from the one in which start was asserted.
    task automatic check_cycle(input int t);
        int n, wd, l, per, tdone, r, w, s, k, a, b, tw;
        bit rd, wr;
        n     = pts();
        wd    = wdly();
        l     = $clog2(n);
        per   = n / 2 + wd;
        tdone = 1 + l * per;
        chk("busy", t, o_busy, 32'(t >= 1 && t < tdone));
        chk("done", t, o_done, 32'(t == tdone));
        r  = t - 1;
        rd = r >= 0 && r / per < l && r % per < n / 2;
        chk("rd_en", t, o_rd_en, 32'(rd));
        if (rd) begin
            bf(n, r / per, r % per, a, b, tw);
            chk("rd_addr_a", t, o_rda, a);
            chk("rd_addr_b", t, o_rdb, b);
            chk("tw_idx", t, o_tw, tw);
        end
        if (t >= 1 && t < tdone) begin
            chk("stage", t, o_stage, r / per);
            chk("src_bank", t, o_src, (r / per) % 2);
        end
        w  = t - 1 - wd;
        wr = w >= 0 && w / per < l && w % per < n / 2;
        chk("wr_en", t, o_wr_en, 32'(wr));
        if (wr) begin
            s = w / per;
            k = w % per;
            bf(n, s, k, a, b, tw);
`ifdef BITREV_OUT_EN
            if (s == l - 1) begin
                a = bitrev_i(a, l);
                b = bitrev_i(b, l);
            end
`endif
            chk("wr_addr_a", t, o_wra, a);
            chk("wr_addr_b", t, o_wrb, b);
        end
    endtask

    task automatic set_start(input logic v);
        if (sel != 0) start_b = v;
        else start_a = v;
    endtask

    // Entered and left just after a posedge.
    task automatic run(input int s, input int rst_at, input int gap);
        int tdone, nt;
        bit v;
        sel = s;
        tdone = 1 + $clog2(pts()) * (pts() / 2 + wdly());
        repeat (gap) begin
            @(negedge clk);
            check_idle(-1);
            @(posedge clk);
            #1;
        end
        set_start(1'b1);
        for (int t = 0; t <= tdone + 1; t++) begin
            if (t == rst_at) begin
                #1 rst_n = 1'b0;
                set_start(1'b0);
                #1 check_zero(t);
                @(negedge clk);
                rst_n = 1'b1;
                for (int i = 0; i < 2 * wdly() + 3; i++) begin
                    @(negedge clk);
                    check_idle(t + 1 + i);
                end
                @(posedge clk);
                #1;
                return;
            end
            @(negedge clk);
            check_cycle(t);
            @(posedge clk);
            #1;
            nt = t + 1;
            v  = nt >= 1 && nt <= tdone &&
                 (nt == 5 || nt == tdone ||
                  $urandom_range(3) == 0);
            set_start(v);
        end
        set_start(1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 sel = 0;
        #1 check_zero(-1);
        sel = 1;
        #1 check_zero(-1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run(0, -1, 0);
        run(0, -1, 0);
        run(0, 10, 0);
        run(0, -1, $urandom_range(0, 3));
        run(0, $urandom_range(2, 20), $urandom_range(0, 3));
        run(0, -1, 0);
        run(1, -1, 0);
        run(1, $urandom_range(2, 190), 1);
        run(1, -1, 2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ntt_addr_gen.md
Name: ntt_addr_gen

Overview:
- Control and address stage directly upstream of the two ping-pong mem_dp banks in the NTT datapath.
- Sequences all log2(N) stages of an in-place-indexed radix-2 Gentleman-Sande NTT at one butterfly per cycle:
  - read addresses go to the source bank;
  - delayed write addresses go to the destination bank;
  - a twiddle index goes to the twiddle ROM.
- Bank roles swap after every stage. The pipeline drains at each stage boundary, so no read-after-write hazard can occur.

Parameters:
- N, 64, number of points; power of two, >= 4.
- BF_LAT, 4, butterfly pipeline latency in cycles, from RAM read data valid to result valid; >= 0.
- AW, `CLOG2(N), address width (derived; not to be overridden).
- SW, `CLOG2(`CLOG2(N)), stage counter width (derived).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to begin a transform; ignored while busy.
- busy  out  1  high from the cycle after start is accepted through the cycle of the final write.
- done  out  1  one-cycle pulse, the cycle after the final write.
- rd_en  out  1  read strobe for both ports of the source bank.
- rd_addr_a  out  AW  even (upper) operand address.
- rd_addr_b  out  AW  odd (lower) operand address.
- tw_idx  out  AW-1  twiddle exponent for the butterfly read this cycle.
- wr_en  out  1  write strobe for both ports of the destination bank.
- wr_addr_a  out  AW  write address for butterfly output a.
- wr_addr_b  out  AW  write address for butterfly output b.
- src_bank  out  1  bank currently read; destination bank = ~src_bank.
- stage  out  SW  current stage index, 0..L-1 where L = log2(N).

Behaviour:
- Reset: all outputs, counters and delay-line valid bits are 0; state is IDLE.
- Reset mid-run aborts immediately. No wr_en is produced after rst_n deasserts until a new start.
- States:
  - IDLE: start=1 -> READ, with stage=0, k=0, src_bank=0.
  - READ: rd_en=1 every cycle while k runs 0..N/2-1. After k=N/2-1 -> DRAIN, with drain counter = WR_DLY-1.
  - DRAIN: rd_en=0; counter decrements. At 0: if stage=L-1 -> DONE; else stage+1, src_bank toggles, k=0 -> READ.
  - DONE: done=1 for one cycle, busy=0 -> IDLE.
- WR_DLY = 1 + BF_LAT: one cycle of RAM read latency plus the butterfly latency.
- Addressing for stage s and butterfly k:
  - shift = L-1-s; half = N >> (s+1);
  - group = k >> shift; off = k & (half-1);
  - rd_addr_a = group*2*half + off; rd_addr_b = rd_addr_a + half;
  - tw_idx = off << s, truncated to AW-1 bits.
- All read-side outputs are registered and valid in the same cycle as rd_en.
- Write path: a WR_DLY-deep shift register carries {valid, addr_a, addr_b}. wr_en and wr_addr_* equal the rd_en and rd_addr_* values from exactly WR_DLY cycles earlier.
- The first read of stage s+1 occurs the cycle after the final wr_en of stage s.
- Cycles per stage = N/2 + WR_DLY.
- Timing with start sampled in cycle 0: first rd_en in cycle 1; done in cycle 1 + L*(N/2+WR_DLY).
- start while busy: no effect. start in the DONE cycle: ignored.
- Final result bank = L mod 2.

Optional Feature:
- Macro BITREV_OUT_EN.
- Defined: during the last stage (s=L-1), wr_addr_a/b are the AW-bit bit-reversal of the delayed read addresses, so results land in natural order.
- Undefined: write addresses equal the delayed read addresses; output is in bit-reversed order.
- Read addresses and timing are identical in both builds.

Decomposition:
- Shared package ntt_pkg holds:
  - state encoding localparams (IDLE, READ, DRAIN, DONE);
  - the `CLOG2 macro include;
  - a bitrev function parameterised by AW.
- One sub-module: ntt_wr_delay, a parameterised WR_DLY-deep valid+address pipeline with asynchronous active-low reset. It is reused by the twiddle path.

Test Plan:
- N=8, BF_LAT=2, start in cycle 0 -> rd pairs in stage 0: (0,4),(1,5),(2,6),(3,7) with tw 0,1,2,3, in cycles 1-4; wr_en in cycles 4-7 with matching addresses.
- Same run, stage 1 -> pairs (0,2),(1,3),(4,6),(5,7), tw 0,2,0,2, in cycles 8-11, src_bank=1. Stage 2 -> pairs (0,1),(2,3),(4,5),(6,7), tw 0, in cycles 15-18, src_bank=0. done=1 only in cycle 22.
- start pulsed again in cycles 5 and 22 -> no restart, no glitch on busy; a new start in cycle 24 reproduces identical traces.
- rst_n low in cycle 10 -> all outputs 0 asynchronously; no wr_en in any later cycle until the next start.
- BITREV_OUT_EN defined, N=8 -> stage-2 writes go to (0,4),(2,6),(1,5),(3,7); stages 0-1 are unchanged.
- BF_LAT=0, N=64 -> each stage is 33 cycles; done in cycle 199; wr_addr is always the rd_addr of one cycle earlier.
